// File: rtl/csl_adder_pipe.sv
// csl_adder_pipe: parametrised carry-select adder, one BLOCK-bit block resolved per pipeline stage.
// Latency: NUM_BLK = WIDTH/BLOCK cycles from accept to out_valid; throughput one operation per cycle.
// Backpressure: all stages advance together only when !out_valid || out_ready; in_ready mirrors that.
// Optional build macro CSL_OVF_EN adds output ovf (two's-complement signed overflow of the sum).
module csl_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_BLK = WIDTH / BLOCK;

    // Operands must split into whole blocks; anything else is a configuration error.
    if ((WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("csl_adder_pipe: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    // Per-stage state. x_q holds a rotating word: finished sum blocks enter at the
    // top while unconsumed A blocks shift down, so the next A block always sits at
    // bits [BLOCK-1:0]. After the last stage x_q is exactly the sum. b_q holds the
    // unconsumed B blocks shifted down the same way.
    logic             vld_q [NUM_BLK];
    logic             vld_d [NUM_BLK];
    logic             cy_q  [NUM_BLK];
    logic             cy_d  [NUM_BLK];
    logic [WIDTH-1:0] x_q   [NUM_BLK];
    logic [WIDTH-1:0] x_d   [NUM_BLK];
    logic [WIDTH-1:0] b_q   [NUM_BLK];
    logic [WIDTH-1:0] b_d   [NUM_BLK];

`ifdef CSL_OVF_EN
    // Operand sign bits travel alongside the data; the rotating word loses A's MSB.
    logic             sa_q  [NUM_BLK];
    logic             sa_d  [NUM_BLK];
    logic             sb_q  [NUM_BLK];
    logic             sb_d  [NUM_BLK];
`endif

    // Stage inputs: stage 0 reads the ports, stage k reads stage k-1's registers.
    logic [WIDTH-1:0] a_src [NUM_BLK];
    logic [WIDTH-1:0] b_src [NUM_BLK];
    logic             c_src [NUM_BLK];
    logic             v_src [NUM_BLK];

    // Both carry-in candidates per block, and the one picked by the incoming carry.
    logic [BLOCK:0]   s0    [NUM_BLK];
    logic [BLOCK:0]   s1    [NUM_BLK];
    logic [BLOCK:0]   sel   [NUM_BLK];

    logic             adv;

    // Whole pipeline moves in lockstep; it only stalls when a finished result is refused.
    assign adv       = !vld_q[NUM_BLK-1] || out_ready;
    assign in_ready  = adv;

    assign out_valid = vld_q[NUM_BLK-1];
    assign sum       = x_q[NUM_BLK-1];
    assign cout      = cy_q[NUM_BLK-1];

`ifdef CSL_OVF_EN
    assign ovf = (sa_q[NUM_BLK-1] == sb_q[NUM_BLK-1]) &&
                 (x_q[NUM_BLK-1][WIDTH-1] != sa_q[NUM_BLK-1]);
`endif

    // Route each stage's operands: ports into stage 0, previous stage registers onward.
    always_comb begin
        a_src[0] = A;
        b_src[0] = B;
        c_src[0] = cin;
        v_src[0] = in_valid;
        for (int k = 1; k < NUM_BLK; k++) begin
            a_src[k] = x_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = cy_q[k-1];
            v_src[k] = vld_q[k-1];
        end
    end

    // Carry-select block adders and next-state for every stage.
    always_comb begin
        for (int k = 0; k < NUM_BLK; k++) begin
            s0[k]    = {1'b0, a_src[k][BLOCK-1:0]} + {1'b0, b_src[k][BLOCK-1:0]};
            s1[k]    = {1'b0, a_src[k][BLOCK-1:0]} + {1'b0, b_src[k][BLOCK-1:0]}
                       + {{BLOCK{1'b0}}, 1'b1};
            sel[k]   = c_src[k] ? s1[k] : s0[k];
            // Drop the consumed A block from the bottom, insert its sum block at the top.
            x_d[k]   = (a_src[k] >> BLOCK) | (WIDTH'(sel[k][BLOCK-1:0]) << (WIDTH - BLOCK));
            b_d[k]   = b_src[k] >> BLOCK;
            cy_d[k]  = sel[k][BLOCK];
            vld_d[k] = v_src[k];
        end
    end

`ifdef CSL_OVF_EN
    // Sign-bit skew chain for the overflow flag.
    always_comb begin
        sa_d[0] = A[WIDTH-1];
        sb_d[0] = B[WIDTH-1];
        for (int k = 1; k < NUM_BLK; k++) begin
            sa_d[k] = sa_q[k-1];
            sb_d[k] = sb_q[k-1];
        end
    end

    // Sign-bit registers share the pipeline's reset and advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BLK; k++) begin
                sa_q[k] <= 1'b0;
                sb_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NUM_BLK; k++) begin
                sa_q[k] <= sa_d[k];
                sb_q[k] <= sb_d[k];
            end
        end
    end
`endif

    // Stage registers: synchronous clear discards everything in flight; otherwise
    // every stage loads together on advance and holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BLK; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                x_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NUM_BLK; k++) begin
                vld_q[k] <= vld_d[k];
                cy_q[k]  <= cy_d[k];
                x_q[k]   <= x_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

endmodule

// File: tb/tb_csl_adder_pipe.sv
// tb_csl_adder_pipe: directed vector table plus hand sequences for csl_adder_pipe (WIDTH=32, BLOCK=8).
// Latency: expects results exactly 4 cycles after accept.
// Backpressure: exercises output stalls, mid-flight reset and random valid/ready.
module tb_csl_adder_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CSL_OVF_EN
    logic        ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csl_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl [13];

    logic [32:0] exp_q [$];
    logic [32:0] got_q [$];
    int          got_t [$];
    bit          mon_en  = 1'b0;
    int          acc_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: outputs are checked before accepts are recorded so an op can never match itself.
    always @(negedge clk) begin
        #1;
        if (mon_en && rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                got_q.push_back({cout, sum});
                got_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious output: got %0h, none expected", {cout, sum});
                end else begin
                    check("scoreboard", {31'b0, cout, sum}, {31'b0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, A} + {1'b0, B} + {32'b0, cin});
                acc_cnt++;
            end
        end
    end

    // Single operation into an empty pipeline, checking exact latency and the bubble after it.
    task automatic one_beat(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = v.a;
        B         = v.b;
        cin       = v.c;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        check({tag, " latency"}, lat, LAT);
        check({tag, " sum"}, sum, v.s);
        check({tag, " cout"}, cout, v.co);
`ifdef CSL_OVF_EN
        check({tag, " ovf"}, ovf, v.ov);
`endif
        @(negedge clk);
        check({tag, " out_valid drop"}, out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [32:0] held;
        int stall;
        bit seen;

        //            a              b              c     sum            cout  ovf
        tbl[0]  = '{32'h00000002, 32'h00000005, 1'b1, 32'h00000008, 1'b0, 1'b0};
        tbl[1]  = '{32'h00000001, 32'h00000010, 1'b0, 32'h00000011, 1'b0, 1'b0};
        tbl[2]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[3]  = '{32'h0000FF00, 32'h00000100, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tbl[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[7]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[8]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0, 1'b0};
        tbl[9]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        tbl[10] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[11] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[12] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        check("reset sum", sum, 32'h0);
        check("reset cout", cout, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Directed table, one operation at a time.
        for (int i = 0; i < 13; i++) begin
            one_beat(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream with out_ready held high.
        exp_q.delete(); got_q.delete(); got_t.delete(); mon_en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = tbl[i].a; B = tbl[i].b; cin = tbl[i].c;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && got_q.size() < 3; c++) @(negedge clk);
        check("stream count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("stream r0", got_q[0], 33'h0_00000011);
            check("stream r1", got_q[1], 33'h1_00000000);
            check("stream r2", got_q[2], 33'h0_00010000);
            check("stream gap01", got_t[1] - got_t[0], 1);
            check("stream gap12", got_t[2] - got_t[1], 1);
        end

        // Six ops with a 5-cycle output stall once the first result appears.
        exp_q.delete(); got_q.delete(); got_t.delete(); acc_cnt = 0;
        stall = 0; seen = 1'b0; held = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 5;
                held  = {cout, sum};
            end
            out_ready = (stall > 0) ? 1'b0 : 1'b1;
            if (acc_cnt < 6) begin
                in_valid = 1'b1;
                A        = 32'h100 * (acc_cnt + 1);
                B        = acc_cnt + 3;
                cin      = acc_cnt[0];
            end else begin
                in_valid = 1'b0;
            end
            #2;
            if (stall > 0) begin
                check("stall in_ready", in_ready, 1'b0);
                check("stall out_valid", out_valid, 1'b1);
                if (stall < 5) check("stall sum held", {cout, sum}, held);
                stall--;
            end
            if (seen && stall == 0 && got_q.size() == 6) break;
        end
        check("stall delivered", got_q.size(), 6);
        check("stall leftover", exp_q.size(), 0);

        // Reset while three ops are in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = i + 1; B = i + 10; cin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        check("midreset sum", sum, 32'h0);
        check("midreset cout", cout, 1'b0);
        for (int c = 0; c < 8; c++) begin
            #2;
            check("midreset out_valid", out_valid, 1'b0);
            @(negedge clk);
        end
        mon_en = 1'b0;
        v = '{32'h11111111, 32'h22222222, 1'b1, 32'h33333334, 1'b0, 1'b0};
        one_beat(v, "post-reset");

        // Random operands with random valid/ready.
        exp_q.delete(); got_q.delete(); got_t.delete(); acc_cnt = 0; mon_en = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (acc_cnt >= 1000 && exp_q.size() == 0) break;
            in_valid = (acc_cnt < 1000) && ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       A = 32'hFFFFFFFF;
                1:       A = 32'h0;
                default: A = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       B = 32'hFFFFFFFF;
                1:       B = 32'h0;
                default: B = $urandom;
            endcase
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        in_valid = 1'b0;
        mon_en   = 1'b0;
        check("random accepted", acc_cnt, 1000);
        check("random drained", exp_q.size(), 0);
        check("random delivered", got_q.size(), 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
